// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and FIFO payload for the TDM receive framer.
package tdm_pkg;

    localparam int unsigned WORD_BITS           = 32;
    localparam int unsigned DEF_FRAME_SLOTS     = 64;
    localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
    localparam int unsigned DEF_FIFO_DEPTH      = 4;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef struct packed {
        logic                 last;
        logic [WORD_BITS-1:0] data;
    } word_entry_t;

endpackage

// File: rtl/tdm_word_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module tdm_word_fifo
    import tdm_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        push,
    input  word_entry_t push_data,
    input  logic        pop,
    output word_entry_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    word_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push_c;
    logic          do_pop_c;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tdm_rx_framer.sv
// TDM receive framer: synchronizes c4/f0/data into clk50, tracks frame slots and
// packs even-slot samples into 32-bit words queued for a ready/valid consumer.
module tdm_rx_framer
    import tdm_pkg::*;
#(
    parameter int unsigned FRAME_SLOTS     = DEF_FRAME_SLOTS,
    parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                 clk50,
    input  logic                 reset_n,
    input  logic                 c4,
    input  logic                 f0,
    input  logic                 data_from_dt,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_last,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 block_done,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 sync_lock
);

    localparam int unsigned SLOT_W = $clog2(FRAME_SLOTS + 1);
    localparam int unsigned BIT_W  = $clog2(WORD_BITS);
    localparam int unsigned IDX_W  = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

    logic c4_meta, c4_sync, c4_prev;
    logic f0_meta, f0_sync;
    logic dt_meta, dt_sync;
    logic evt_q, f0_q, dt_q;

    state_t               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [WORD_BITS-1:0] word_q, word_d, word_c;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BIT_W-1:0]     bit_idx_c;
    logic                 push_c, err_c, last_c;

    word_entry_t push_entry_c, pop_entry;
    logic        fifo_full, fifo_empty, pop_c;

    // Two-flop synchronizers, then one aligned stage carrying the c4 rise event.
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            c4_meta <= 1'b0; c4_sync <= 1'b0; c4_prev <= 1'b0;
            f0_meta <= 1'b0; f0_sync <= 1'b0;
            dt_meta <= 1'b0; dt_sync <= 1'b0;
            evt_q   <= 1'b0; f0_q    <= 1'b0; dt_q <= 1'b0;
        end else begin
            c4_meta <= c4;           c4_sync <= c4_meta; c4_prev <= c4_sync;
            f0_meta <= f0;           f0_sync <= f0_meta;
            dt_meta <= data_from_dt; dt_sync <= dt_meta;
            evt_q   <= c4_sync & ~c4_prev;
            f0_q    <= f0_sync;
            dt_q    <= dt_sync;
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    assign bit_idx_c = BIT_W'(slot_q >> 1);
    assign last_c    = (idx_q == IDX_W'(WORDS_PER_BLOCK - 1));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        word_d  = word_q;
        idx_d   = idx_q;
        word_c  = word_q;
        push_c  = 1'b0;
        err_c   = 1'b0;
        if (evt_q) begin
            case (state_q)
                HUNT: begin
                    if (!f0_q) begin
                        state_d = LOCK;
                        slot_d  = '0;
                        word_d  = '0;
                    end
                end
                LOCK: begin
                    if (!f0_q) begin
                        // Marker at slot 0 or just after a full frame is expected.
                        if (slot_q != '0 && slot_q != SLOT_W'(FRAME_SLOTS)) begin
                            err_c = 1'b1;
                        end
                        slot_d = '0;
                        word_d = '0;
                    end else if (slot_q == SLOT_W'(FRAME_SLOTS)) begin
                        err_c   = 1'b1;
                        state_d = HUNT;
                        slot_d  = '0;
                        word_d  = '0;
                        idx_d   = '0;
                    end else begin
                        if (!slot_q[0]) begin
                            word_c[bit_idx_c] = dt_q;
                        end
                        if (slot_q == SLOT_W'(FRAME_SLOTS - 2)) begin
                            push_c = 1'b1;
                            word_d = '0;
                            idx_d  = last_c ? '0 : idx_q + IDX_W'(1);
                        end else begin
                            word_d = word_c;
                        end
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign push_entry_c = '{last: last_c, data: word_c};
    assign pop_c        = ~fifo_empty & word_ready;

    tdm_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk50    (clk50),
        .reset_n  (reset_n),
        .push     (push_c),
        .push_data(push_entry_c),
        .pop      (pop_c),
        .pop_data (pop_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Status pulses; block_done only for a block-final word that actually enters the FIFO.
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            block_done <= 1'b0;
        end else begin
            frame_err  <= err_c;
            overflow   <= push_c & fifo_full & ~pop_c;
            block_done <= push_c & last_c & (~fifo_full | pop_c);
        end
    end

    assign word_valid = ~fifo_empty;
    assign word_data  = pop_entry.data;
    assign word_last  = pop_entry.last;
    assign sync_lock  = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_rx_framer.sv
// Scoreboard bench for tdm_rx_framer: directed TDM frames, expected words queued at
// slot 62 and checked by a monitor on every FIFO pop.
`timescale 1ns/1ps
module tb_tdm_rx_framer;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        c4 = 1'b0;
    logic        f0 = 1'b1;
    logic        data_from_dt = 1'b0;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic        word_last, word_valid, block_done, frame_err, overflow, sync_lock;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n_err = 0;
    int   n_ovf = 0;
    int   n_bd = 0;
    int   exp_idx = 0;

    always #10 clk50 = ~clk50;

    tdm_rx_framer dut (
        .clk50       (clk50),
        .reset_n     (reset_n),
        .c4          (c4),
        .f0          (f0),
        .data_from_dt(data_from_dt),
        .word_data   (word_data),
        .word_last   (word_last),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .block_done  (block_done),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .sync_lock   (sync_lock)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts status pulses and checks each popped word against the scoreboard.
    always @(negedge clk50) begin
        exp_t e;
        if (reset_n) begin
            if (frame_err)  n_err++;
            if (overflow)   n_ovf++;
            if (block_done) n_bd++;
            if (word_valid && word_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", word_data);
                end else begin
                    e = sb.pop_front();
                    check("word_data", word_data, e.data);
                    check("word_last", 32'(word_last), 32'(e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic c4_event(input logic fv, input logic dv);
        c4 = 1'b0; f0 = fv; data_from_dt = dv;
        tick(); tick();
        c4 = 1'b1;
        tick(); tick();
    endtask

    task automatic send_partial(input int n);
        c4_event(1'b0, 1'b0);
        for (int s = 0; s < n; s++) c4_event(1'b1, 1'(s % 3 == 0));
    endtask

    // One f0-low marker then 64 f0-high slots; the slot-62 event completes the word.
    task automatic send_frame(input logic [31:0] w, input bit expect_push, input bit lat_chk);
        logic dv;
        exp_t e;
        c4_event(1'b0, 1'b0);
        for (int s = 0; s < 64; s++) begin
            dv = (s % 2 == 0) ? w[s/2] : 1'b1;
            if (s == 62) begin
                e.last = (exp_idx == 7);
                e.data = w;
                exp_idx = (exp_idx + 1) % 8;
                if (expect_push) sb.push_back(e);
            end
            if (s == 62 && lat_chk) begin
                c4 = 1'b0; f0 = 1'b1; data_from_dt = dv;
                tick(); tick();
                c4 = 1'b1;
                tick(); tick(); tick();
                check("latency_3cyc_valid", 32'(word_valid), 32'd0);
                tick();
                check("latency_4cyc_valid", 32'(word_valid), 32'd1);
            end else begin
                c4_event(1'b1, dv);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || word_valid) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL drain_timeout: %0d words pending expected 0", sb.size());
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at 5ms expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] blk [8];
        logic [31:0] ovw [8];
        int          ovf0;
        blk = '{32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001,
                32'h8000_0000, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'h0F0F_0F0F};
        ovw = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};

        // Reset state
        reset_n = 1'b0;
        tick(); tick(); tick();
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_sync_lock",  32'(sync_lock),  32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_block_done", 32'(block_done), 32'd0);
        check("rst_word_data",  word_data,       32'd0);
        check("rst_word_last",  32'(word_last),  32'd0);
        reset_n = 1'b1;
        word_ready = 1'b1;
        tick();

        // First frame with latency check, then a full block of 8
        send_frame(blk[0], 1'b1, 1'b1);
        check("lock_after_frame", 32'(sync_lock), 32'd1);
        for (int i = 1; i < 8; i++) send_frame(blk[i], 1'b1, 1'b0);
        drain();
        check("block_done_count_1", 32'(n_bd), 32'd1);
        check("no_frame_err_yet", 32'(n_err), 32'd0);

        // Early marker at slot 20, next frame still delivered (index wrapped to 0)
        send_partial(20);
        send_frame(32'h1357_9BDF, 1'b1, 1'b0);
        drain();
        check("early_marker_err", 32'(n_err), 32'd1);

        // Frame overrun drops lock; data ignored until next marker
        send_frame(32'h2468_ACE0, 1'b1, 1'b0);
        c4_event(1'b1, 1'b1);
        tick(); tick(); tick();
        check("overrun_err", 32'(n_err), 32'd2);
        check("overrun_unlock", 32'(sync_lock), 32'd0);
        exp_idx = 0;
        for (int s = 0; s < 70; s++) c4_event(1'b1, 1'(s % 2));
        drain();
        check("hunt_still_unlocked", 32'(sync_lock), 32'd0);
        send_frame(32'hCAFE_F00D, 1'b1, 1'b0);
        drain();
        check("relock", 32'(sync_lock), 32'd1);

        // Reset mid-frame with two words queued
        word_ready = 1'b0;
        send_frame(32'hAAAA_0001, 1'b0, 1'b0);
        send_frame(32'hAAAA_0002, 1'b0, 1'b0);
        send_partial(40);
        check("queued_before_reset", 32'(word_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        check("reset_flush_valid", 32'(word_valid), 32'd0);
        check("reset_unlock", 32'(sync_lock), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        exp_idx = 0;
        word_ready = 1'b1;
        for (int s = 0; s < 10; s++) c4_event(1'b1, 1'b1);
        drain();
        check("post_reset_ignored", 32'(sync_lock), 32'd0);

        // Stall: four words held, two dropped, block end still on the 8th word
        word_ready = 1'b0;
        ovf0 = n_ovf;
        for (int i = 0; i < 6; i++) send_frame(ovw[i], (i < 4), 1'b0);
        tick(); tick(); tick(); tick();
        check("overflow_pulses", 32'(n_ovf - ovf0), 32'd2);
        check("stall_valid", 32'(word_valid), 32'd1);
        check("stall_head_data", word_data, ovw[0]);
        check("stall_head_last", 32'(word_last), 32'd0);
        word_ready = 1'b1;
        drain();
        send_frame(ovw[6], 1'b1, 1'b0);
        send_frame(ovw[7], 1'b1, 1'b0);
        drain();
        check("block_done_count_2", 32'(n_bd), 32'd2);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_rx_framer.md
TDM_RX_FRAMER -- requirements
Module: tdm_rx_framer

Interface
REQ-001 Parameter FRAME_SLOTS, default 64: c4 rising edges per frame with f0 high.
REQ-002 Parameter WORDS_PER_BLOCK, default 8: words per block; word_last and block_done mark the block boundary.
REQ-003 Parameter FIFO_DEPTH, default 4: output word FIFO entries.
REQ-004 clk50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 c4  in  1  asynchronous TDM bit clock.
REQ-007 f0  in  1  asynchronous frame sync; low = frame marker.
REQ-008 data_from_dt  in  1  asynchronous TDM serial data.
REQ-009 word_data  out  32  assembled word, bit k = slot-2k sample.
REQ-010 word_last  out  1  qualifies word_data as the final word of a block.
REQ-011 word_valid  out  1  FIFO non-empty.
REQ-012 word_ready  in  1  downstream accept.
REQ-013 block_done  out  1  one-cycle pulse when a block-final word is pushed.
REQ-014 frame_err  out  1  one-cycle pulse on a sync violation.
REQ-015 overflow  out  1  one-cycle pulse when a completed word is dropped.
REQ-016 sync_lock  out  1  high in state LOCK.

Function
REQ-017 c4, f0 and data_from_dt SHALL each pass a 2-flop synchronizer; a c4 rise event is synced c4 high with the previous synced value low.
REQ-018 clk50 SHALL be at least 4x the c4 frequency; behaviour at lower ratios is undefined.
REQ-019 State HUNT: ignore data; a c4 event with f0 low SHALL enter LOCK with slot=0.
REQ-020 LOCK, c4 event, f0 low, slot=0: hold slot=0, no sample.
REQ-021 LOCK, c4 event, f0 high, slot<FRAME_SLOTS: on even slot, write synced data to word bit slot/2; then slot=slot+1.
REQ-022 Sampling slot 62 SHALL complete the word and push it, with word_last, the same clk50 cycle.
REQ-023 LOCK, c4 event, f0 high, slot=FRAME_SLOTS: pulse frame_err, discard the partial word, enter HUNT.
REQ-024 LOCK, c4 event, f0 low, slot in 1..FRAME_SLOTS-1: pulse frame_err, discard the partial word, slot=0, stay LOCK.
REQ-025 The block word index (0..WORDS_PER_BLOCK-1) SHALL increment on every completed word, pushed or dropped, wrapping to 0.
REQ-026 word_last SHALL be set when the block word index is WORDS_PER_BLOCK-1; block_done pulses on that push.
REQ-027 Entering HUNT SHALL reset the block word index to 0.
REQ-028 A FIFO push SHALL be accepted if not full or if a pop occurs in the same cycle.
REQ-029 When a push is refused: drop the word, pulse overflow, FIFO unchanged.
REQ-030 Pop occurs when word_valid and word_ready are both high.
REQ-031 word_data and word_last SHALL remain stable while word_valid is high and word_ready is low.
REQ-032 Latency from the c4 pin edge at slot 62 to word_valid high (FIFO empty): 4 clk50 cycles.

Reset
REQ-033 When reset_n is low at a clk50 edge: state HUNT, slot 0, word index 0, FIFO empty, synchronizers 0, all outputs 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial word and all FIFO contents; after release, data is ignored until the next f0-low c4 event.

Structure
REQ-035 Package tdm_pkg SHALL hold WORD_BITS=32, default FRAME_SLOTS/WORDS_PER_BLOCK, and the HUNT/LOCK state enum.
REQ-036 The FIFO SHALL be a sub-module, tdm_word_fifo: 33-bit wide, FIFO_DEPTH deep, full/empty flags, same clock and reset.

Verification
REQ-037 After reset, one f0-low c4 event, then 64 c4 events with data pattern 0xA5A5_0F0F on even slots -> word_data=0xA5A50F0F, word_valid 4 clk50 cycles after slot 62, sync_lock=1.
REQ-038 8 consecutive good frames, word_ready=1 -> word_last and block_done only on the 8th word; index then wraps to 0.
REQ-039 f0 low at slot 20 -> frame_err pulses once, no word pushed, next full frame delivers its word normally.
REQ-040 65th f0-high c4 event -> frame_err, sync_lock=0, data ignored until an f0-low event.
REQ-041 word_ready=0 for 6 frames -> 4 words held, overflow pulses on words 5 and 6, and the 8th word still carries word_last.
REQ-042 reset_n low at slot 40 with 2 words queued -> word_valid=0, sync_lock=0 the next cycle.
